alu_seq_n: RTL and testbench

ALU_SEQ_N -- requirements
Module: alu_seq_n

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_n_if.sv | 29 ++
 rtl/mul_shift_add.sv | 46 ++++
 rtl/alu_seq_n.sv | 153 +++++++++++++++
 tb/tb_alu_seq_n.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU.
// Op encoding and controller state.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SHR = 3'b010,
    OP_SHL = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_seq_n_if.sv
// Request/result bundle of the sequential ALU.
// master issues requests, slave returns results.
interface alu_seq_n_if #(
  parameter int N = 4
);

  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] r;
  logic         Nf;
  logic         Zf;
  logic         Cf;
  logic         Vf;
  logic         busy;
  logic         done;

  modport master (
    output start, op, a, b,
    input  r, Nf, Zf, Cf, Vf, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output r, Nf, Zf, Cf, Vf, busy, done
  );

endinterface

// File: rtl/mul_shift_add.sv
// Shift-add multiplier, one multiplier bit per cycle.
// done marks the cycle whose prod is the final product.
module mul_shift_add #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int CW = $clog2(N) + 1;

  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] addend;

  assign addend = mplier[0] ? mcand : '0;
  assign prod   = acc + addend;
  assign done   = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(N);
    end else if (cnt != '0) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_n.sv
// Multi-cycle ALU: single-cycle ops in EXEC,
// multiply delegated to the shift-add unit.
module alu_seq_n
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_n_if.slave   bus
);

  localparam int SW = $clog2(N);

  state_e       state;
  op_e          opl;
  logic [N-1:0] al;
  logic [N-1:0] bl;
  logic [N-1:0] r_q;
  logic         nf_q;
  logic         zf_q;
  logic         cf_q;
  logic         vf_q;
  logic         busy_q;
  logic         done_q;

  logic [N-1:0]   res;
  logic           cf;
  logic           vf;
  logic [N:0]     sum;
  logic [N:0]     dif;
  logic [N:0]     shr_x;
  logic [N:0]     shl_x;
  logic [SW-1:0]  sh;
  logic           mgo;
  logic           mdone;
  logic [2*N-1:0] prod;

  assign mgo = (state == EXEC) && (opl == OP_MUL);

  mul_shift_add #(.N(N)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mgo),
    .a     (al),
    .b     (bl),
    .done  (mdone),
    .prod  (prod)
  );

  // Extra low/high bit catches the last bit shifted out.
  always_comb begin
    sh    = bl[SW-1:0];
    sum   = {1'b0, al} + {1'b0, bl};
    dif   = {1'b0, al} - {1'b0, bl};
    shr_x = {al, 1'b0} >> sh;
    shl_x = {1'b0, al} << sh;
    res   = '0;
    cf    = 1'b0;
    vf    = 1'b0;
    unique case (opl)
      OP_ADD: begin
        res = sum[N-1:0];
        cf  = sum[N];
        vf  = (al[N-1] == bl[N-1]) &&
              (sum[N-1] != al[N-1]);
      end
      OP_SUB: begin
        res = dif[N-1:0];
        cf  = dif[N];
        vf  = (al[N-1] != bl[N-1]) &&
              (dif[N-1] != al[N-1]);
      end
      OP_SHR: begin
        res = shr_x[N:1];
        cf  = shr_x[0];
      end
      OP_SHL: begin
        res = shl_x[N-1:0];
        cf  = shl_x[N];
      end
      OP_AND: res = al & bl;
      OP_OR:  res = al | bl;
      OP_XOR: res = al ^ bl;
      OP_MUL: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opl    <= OP_ADD;
      al     <= '0;
      bl     <= '0;
      r_q    <= '0;
      nf_q   <= 1'b0;
      zf_q   <= 1'b0;
      cf_q   <= 1'b0;
      vf_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            opl    <= op_e'(bus.op);
            al     <= bus.a;
            bl     <= bus.b;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (opl == OP_MUL) begin
            state <= MUL;
          end else begin
            r_q   <= res;
            nf_q  <= res[N-1];
            zf_q  <= (res == '0);
            cf_q  <= cf;
            vf_q  <= vf;
            state <= DONE;
          end
        end
        MUL: begin
          if (mdone) begin
            r_q   <= prod[N-1:0];
            nf_q  <= prod[N-1];
            zf_q  <= (prod[N-1:0] == '0);
            cf_q  <= |prod[2*N-1:N];
            vf_q  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.r    = r_q;
  assign bus.Nf   = nf_q;
  assign bus.Zf   = zf_q;
  assign bus.Cf   = cf_q;
  assign bus.Vf   = vf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// Randomized bench for alu_seq_n against an
// arithmetic reference model.
module tb_alu_seq_n;

  localparam int N = 4;
  localparam int M = 1 << N;
  localparam int H = M / 2;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  alu_seq_n_if #(.N(N)) bus ();

  alu_seq_n #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= H) ? x - M : x;
  endfunction

  // returns {r, n, z, c, v}
  function automatic logic [N+3:0] model(
    input int op, input int a, input int b);
    int r, c, v, s, sv, sa;
    c = 0;
    v = 0;
    sa = b % N;
    case (op)
      0: begin
        s = a + b; r = s % M; c = int'(s >= M);
        sv = sgn(a) + sgn(b);
        v = int'(sv < -H || sv >= H);
      end
      1: begin
        s = a - b; r = (s + M) % M; c = int'(a < b);
        sv = sgn(a) - sgn(b);
        v = int'(sv < -H || sv >= H);
      end
      2: begin
        r = a >> sa;
        c = (sa == 0) ? 0 : (a >> (sa - 1)) & 1;
      end
      3: begin
        r = (a << sa) % M;
        c = (sa == 0) ? 0 : (a >> (N - sa)) & 1;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: begin
        s = a * b; r = s % M; c = int'(s >= M);
      end
    endcase
    return {N'(r), r >= H, r == 0, c[0], v[0]};
  endfunction

  task automatic run_op(input string tag, input int op,
                        input int a, input int b,
                        input bit junk);
    logic [N+3:0] e;
    int cyc;
    bit seen;
    e = model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'(op);
    bus.a = N'(a);
    bus.b = N'(b);
    @(posedge clk);
    #1;
    check({tag, ".busy"}, 32'(bus.busy), 1);
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      if (junk) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op = 3'($urandom_range(0, 7));
        bus.a = N'($urandom);
        bus.b = N'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    check({tag, ".lat"}, seen ? cyc : 999,
          (op == 7) ? N + 2 : 2);
    check({tag, ".r"}, 32'(bus.r), 32'(e[N+3:4]));
    check({tag, ".N"}, 32'(bus.Nf), 32'(e[3]));
    check({tag, ".Z"}, 32'(bus.Zf), 32'(e[2]));
    check({tag, ".C"}, 32'(bus.Cf), 32'(e[1]));
    check({tag, ".V"}, 32'(bus.Vf), 32'(e[0]));
    check({tag, ".idle"}, 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(bus.done), 0);
    check({tag, ".hold"}, 32'(bus.r), 32'(e[N+3:4]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check("rst.r", 32'(bus.r), 0);
    check("rst.flags",
          32'({bus.Nf, bus.Zf, bus.Cf, bus.Vf}), 0);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add7_9", 0, 7, 9, 0);
    run_op("add7_1", 0, 7, 1, 0);
    run_op("sub3_5", 1, 3, 5, 0);
    run_op("mul5_3", 7, 5, 3, 1);
    run_op("mul6_3", 7, 6, 3, 1);
    run_op("shl9_1", 3, 9, 1, 0);
    run_op("shr6_2", 2, 6, 2, 0);
    run_op("shr_0", 2, 11, 0, 0);
    run_op("shl_3", 3, 3, 3, 1);
    run_op("mulff", 7, M - 1, M - 1, 1);

    // abort a multiply by reset
    run_op("pre", 0, 7, 1, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd7;
    bus.a = N'(5);
    bus.b = N'(3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort.r", 32'(bus.r), 0);
    check("abort.flags",
          32'({bus.Nf, bus.Zf, bus.Cf, bus.Vf}), 0);
    check("abort.busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (N + 4) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1;
    end
    check("abort.nodone", 32'(seen), 0);
    run_op("post", 0, 2, 3, 0);

    for (int i = 0; i < 60; i++) begin
      run_op($sformatf("rnd%0d", i),
             int'($urandom_range(0, 7)),
             int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, M - 1)),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
